plot_port_arbiter: RTL

- Shares the single per-column plot interface (col_select / row_select / pixel_color with return_sig acknowledge) between two requesters.
- Requester 0 is the HPS-mailbox point plotter; requester 1 is the heat-grid sweep.
- Grants one pixel write at a time using round-robin, runs the four-phase column handshake, and retires stalled writes on timeout.
- Sits between the plot-request sources and the column draw units.

---
 rtl/plot_arb_pkg.sv | 20 ++
 rtl/rr_pick2.sv | 20 ++
 rtl/plot_port_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/plot_arb_pkg.sv
// Shared definitions for the plot-port arbiter and its requesters (mailbox reader, grid sweep).
package plot_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam int COL_W_DEF   = 6;
    localparam int ROW_W_DEF   = 10;
    localparam int COLOR_W_DEF = 8;

    localparam logic [15:0] ERR_MAX = 16'hFFFF;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == ERR_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to whoever was not served last.
module rr_pick2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant_any,
    output logic       grant_idx
);

    always_comb begin
        grant_any = |valid;
        grant_idx = 1'b0;
        case (valid)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last_grant;
            default: grant_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/plot_port_arbiter.sv
// Shares the per-column plot interface between the mailbox plotter (0) and the grid sweep (1),
// one pixel write at a time with a four-phase column handshake and per-phase timeout.
//   state   | meaning
//   IDLE    | no write in flight; arbitrate and capture the winner's fields
//   WAIT    | col_select asserted, waiting for return_sig[col] to rise
//   RELEASE | col_select dropped, waiting for return_sig[col] to fall
module plot_port_arbiter
    import plot_arb_pkg::*;
#(
    parameter int N_COLS  = 64,
    parameter int COL_W   = COL_W_DEF,
    parameter int ROW_W   = ROW_W_DEF,
    parameter int COLOR_W = COLOR_W_DEF,
    parameter int TIMEOUT = 1023
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [1:0]           req_valid,
    input  logic [2*COL_W-1:0]   req_col,
    input  logic [2*ROW_W-1:0]   req_row,
    input  logic [2*COLOR_W-1:0] req_color,
    output logic [1:0]           req_ready,
    output logic [1:0]           req_done,
    output logic [1:0]           req_err,
    output logic [N_COLS-1:0]    col_select,
    output logic [ROW_W-1:0]     row_select,
    output logic [COLOR_W-1:0]   pixel_color,
    input  logic [N_COLS-1:0]    return_sig,
    output logic                 busy,
    output logic [15:0]          err_count
);

    localparam int TIMER_W = $clog2(TIMEOUT + 1);

    arb_state_t          state;
    logic [TIMER_W-1:0]  timer;
    logic                gnt;
    logic                last_grant;
    logic [COL_W-1:0]    col_q;
    logic                grant_any;
    logic                grant_idx;
    logic [COL_W-1:0]    pick_col;
    logic [ROW_W-1:0]    pick_row;
    logic [COLOR_W-1:0]  pick_color;
    logic [N_COLS-1:0]   pick_onehot;
    logic [1:0]          pick_vec;
    logic [1:0]          gnt_vec;
    logic                col_ok;
    logic                ack;
    logic                timer_hit;

    rr_pick2 u_pick (
        .valid      (req_valid),
        .last_grant (last_grant),
        .grant_any  (grant_any),
        .grant_idx  (grant_idx)
    );

    assign pick_col    = grant_idx ? req_col[2*COL_W-1:COL_W]       : req_col[COL_W-1:0];
    assign pick_row    = grant_idx ? req_row[2*ROW_W-1:ROW_W]       : req_row[ROW_W-1:0];
    assign pick_color  = grant_idx ? req_color[2*COLOR_W-1:COLOR_W] : req_color[COLOR_W-1:0];
    assign col_ok      = (int'(pick_col) < N_COLS);
    assign pick_onehot = {{(N_COLS-1){1'b0}}, 1'b1} << pick_col;
    assign pick_vec    = grant_idx ? 2'b10 : 2'b01;
    assign gnt_vec     = gnt ? 2'b10 : 2'b01;
    // Only the granted column's acknowledge matters; the others may be busy with their own draws.
    assign ack         = return_sig[col_q];
    assign timer_hit   = (timer == TIMER_W'(TIMEOUT));
    assign busy        = (state != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            timer       <= '0;
            gnt         <= 1'b0;
            last_grant  <= 1'b1;
            col_q       <= '0;
            req_ready   <= '0;
            req_done    <= '0;
            req_err     <= '0;
            col_select  <= '0;
            row_select  <= '0;
            pixel_color <= '0;
            err_count   <= '0;
        end else begin
            req_ready <= '0;
            req_done  <= '0;
            req_err   <= '0;
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (grant_any) begin
                        gnt         <= grant_idx;
                        last_grant  <= grant_idx;
                        col_q       <= pick_col;
                        row_select  <= pick_row;
                        pixel_color <= pick_color;
                        req_ready   <= pick_vec;
                        if (col_ok) begin
                            col_select <= pick_onehot;
                            state      <= WAIT;
                        end else begin
                            req_err   <= pick_vec;
                            err_count <= sat_inc(err_count);
                        end
                    end
                end
                WAIT: begin
                    if (ack) begin
                        col_select <= '0;
                        req_done   <= gnt_vec;
                        timer      <= '0;
                        state      <= RELEASE;
                    end else if (timer_hit) begin
                        col_select <= '0;
                        req_err    <= gnt_vec;
                        err_count  <= sat_inc(err_count);
                        timer      <= '0;
                        state      <= RELEASE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RELEASE: begin
                    // A stuck ack is counted but not reported: the requester already got its answer.
                    if (!ack) begin
                        timer <= '0;
                        state <= IDLE;
                    end else if (timer_hit) begin
                        timer     <= '0;
                        err_count <= sat_inc(err_count);
                        state     <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    col_select <= '0;
                    timer      <= '0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
